// File: rtl/argmax_pkg.sv
// Shared defaults and small types for the double-buffered argmax result store.
package argmax_pkg;

  localparam int DEF_FEATURE_ROWS  = 6;
  localparam int DEF_WEIGHT_COLS   = 3;
  localparam int DEF_WEIGHT_WIDTH  = $clog2(DEF_WEIGHT_COLS);
  localparam int DEF_FEATURE_WIDTH = $clog2(DEF_FEATURE_ROWS);

  localparam int MAX_FULL = 2;

  typedef logic [DEF_WEIGHT_WIDTH-1:0] argmax_idx_t;
  typedef logic                        bank_ptr_t;

endpackage

// File: rtl/argmax_bank_mem.sv
// One bank of argmax indices: synchronous write port, all rows visible as a flat vector.
module argmax_bank_mem
  import argmax_pkg::*;
#(
  parameter int ROWS  = DEF_FEATURE_ROWS,
  parameter int WIDTH = DEF_WEIGHT_WIDTH,
  parameter int AW    = DEF_FEATURE_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  output logic [ROWS*WIDTH-1:0] rd_flat
);

  logic [WIDTH-1:0] mem [ROWS];

  // The top only asserts wr_en for in-range addresses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < ROWS; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  for (genvar g = 0; g < ROWS; g++) begin : g_flat
    assign rd_flat[g*WIDTH +: WIDTH] = mem[g];
  end

endmodule

// File: rtl/argmax_pingpong_buffer.sv
// Ping-pong argmax result store: one bank fills from the argmax unit while the other drains.
module argmax_pingpong_buffer
  import argmax_pkg::*;
#(
  parameter int FEATURE_ROWS  = DEF_FEATURE_ROWS,
  parameter int WEIGHT_COLS   = DEF_WEIGHT_COLS,
  parameter int WEIGHT_WIDTH  = $clog2(WEIGHT_COLS),
  parameter int FEATURE_WIDTH = $clog2(FEATURE_ROWS),
  parameter int NUM_BANKS     = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic [FEATURE_WIDTH-1:0]         write_row,
  input  logic [WEIGHT_WIDTH-1:0]          fm_wm_adj_row_in,
  input  logic                             wr_commit,
  output logic                             wr_ready,
  output logic [FEATURE_ROWS-1:0]          row_written,
  output logic                             rd_valid,
  input  logic                             rd_ready,
  output logic [FEATURE_WIDTH-1:0]         rd_row,
  output logic [WEIGHT_WIDTH-1:0]          rd_data,
  output logic                             rd_last,
  output logic [WEIGHT_WIDTH*FEATURE_ROWS-1:0] fm_wm_adj_out,
  output logic                             err_overflow,
  output logic                             err_oob,
  output logic                             err_incomplete
);

  if (NUM_BANKS != 2) begin : g_bank_guard
    $error("argmax_pingpong_buffer supports exactly two banks");
  end

  localparam logic [FEATURE_WIDTH-1:0] LAST_ROW = FEATURE_WIDTH'(FEATURE_ROWS - 1);
  localparam logic [FEATURE_ROWS-1:0]  ALL_ROWS = '1;
  localparam logic [1:0]               FULL_CNT_MAX = 2'(MAX_FULL);

  bank_ptr_t                          wr_bank;
  bank_ptr_t                          rd_bank;
  logic [1:0]                         full_cnt;
  logic                               in_range;
  logic                               wr_ok;
  logic                               commit_ok;
  logic                               rd_hs;
  logic                               last_hs;
  logic [FEATURE_ROWS-1:0]            row_set;
  logic [FEATURE_ROWS-1:0]            rows_after_wr;
  logic [1:0]                         bank_we;
  logic [WEIGHT_WIDTH*FEATURE_ROWS-1:0] bank_flat [2];

  assign wr_ready  = (full_cnt != FULL_CNT_MAX);
  assign rd_valid  = (full_cnt != 2'd0);
  assign rd_last   = (rd_row == LAST_ROW);
  assign in_range  = (write_row <= LAST_ROW);
  assign wr_ok     = wr_en & wr_ready & in_range;
  assign commit_ok = wr_commit & wr_ready;
  assign rd_hs     = rd_valid & rd_ready;
  assign last_hs   = rd_hs & rd_last;

  // A write in the commit cycle lands in the committed bank, so it also counts toward completeness.
  always_comb begin
    row_set = '0;
    if (wr_ok) row_set[write_row] = 1'b1;
    rows_after_wr = row_written | row_set;
  end

  assign bank_we[0] = wr_ok & (wr_bank == 1'b0);
  assign bank_we[1] = wr_ok & (wr_bank == 1'b1);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    argmax_bank_mem #(
      .ROWS  (FEATURE_ROWS),
      .WIDTH (WEIGHT_WIDTH),
      .AW    (FEATURE_WIDTH)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (bank_we[b]),
      .wr_addr (write_row),
      .wr_data (fm_wm_adj_row_in),
      .rd_flat (bank_flat[b])
    );
  end

  assign fm_wm_adj_out = bank_flat[rd_bank];

  always_comb begin
    rd_data = '0;
    for (int r = 0; r < FEATURE_ROWS; r++) begin
      if (rd_row == FEATURE_WIDTH'(r)) rd_data = fm_wm_adj_out[r*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_bank        <= 1'b0;
      rd_bank        <= 1'b0;
      full_cnt       <= 2'd0;
      rd_row         <= '0;
      row_written    <= '0;
      err_overflow   <= 1'b0;
      err_oob        <= 1'b0;
      err_incomplete <= 1'b0;
    end else begin
      if (commit_ok) wr_bank <= ~wr_bank;
      if (last_hs)   rd_bank <= ~rd_bank;

      // Commit and last beat together leave the count unchanged.
      if (commit_ok && !last_hs)      full_cnt <= full_cnt + 2'd1;
      else if (!commit_ok && last_hs) full_cnt <= full_cnt - 2'd1;

      if (rd_hs) rd_row <= rd_last ? '0 : rd_row + 1'b1;

      row_written <= commit_ok ? '0 : rows_after_wr;

      if ((wr_en | wr_commit) & ~wr_ready)          err_overflow   <= 1'b1;
      if (wr_en & ~in_range)                        err_oob        <= 1'b1;
      if (commit_ok && (rows_after_wr != ALL_ROWS)) err_incomplete <= 1'b1;
    end
  end

endmodule

// File: tb/tb_argmax_pingpong_buffer.sv
// Directed bench for argmax_pingpong_buffer with a beat scoreboard fed at commit time.
module tb_argmax_pingpong_buffer;
  import argmax_pkg::*;

  localparam int R  = DEF_FEATURE_ROWS;
  localparam int W  = DEF_WEIGHT_WIDTH;
  localparam int AW = DEF_FEATURE_WIDTH;

  logic            clk = 1'b0;
  logic            rst;
  logic            wr_en;
  logic [AW-1:0]   write_row;
  argmax_idx_t     fm_wm_adj_row_in;
  logic            wr_commit;
  logic            wr_ready;
  logic [R-1:0]    row_written;
  logic            rd_valid;
  logic            rd_ready;
  logic [AW-1:0]   rd_row;
  logic [W-1:0]    rd_data;
  logic            rd_last;
  logic [W*R-1:0]  fm_wm_adj_out;
  logic            err_overflow;
  logic            err_oob;
  logic            err_incomplete;

  always #5 clk = ~clk;

  argmax_pingpong_buffer dut (
    .clk              (clk),
    .rst              (rst),
    .wr_en            (wr_en),
    .write_row        (write_row),
    .fm_wm_adj_row_in (fm_wm_adj_row_in),
    .wr_commit        (wr_commit),
    .wr_ready         (wr_ready),
    .row_written      (row_written),
    .rd_valid         (rd_valid),
    .rd_ready         (rd_ready),
    .rd_row           (rd_row),
    .rd_data          (rd_data),
    .rd_last          (rd_last),
    .fm_wm_adj_out    (fm_wm_adj_out),
    .err_overflow     (err_overflow),
    .err_oob          (err_oob),
    .err_incomplete   (err_incomplete)
  );

  typedef struct {
    logic [AW-1:0]  row;
    logic [W-1:0]   data;
    logic           last;
    logic [W*R-1:0] frame;
  } beat_t;

  beat_t       sbq[$];
  int          checks = 0;
  int          errors = 0;
  int          beats  = 0;
  logic [W-1:0] m_mem [2][R];
  logic        m_wb;
  int          m_full;
  logic [R-1:0] m_rw;
  logic        e_ovf, e_oob, e_inc;

  int fr_1[R] = '{2, 0, 1, 1, 2, 0};
  int fr_a[R] = '{1, 1, 0, 2, 0, 1};
  int fr_b[R] = '{0, 2, 2, 1, 1, 0};
  int fr_c[R] = '{2, 2, 1, 0, 0, 1};
  int fr_d[R] = '{2, 1, 0, 2, 1, 2};
  int fr_e[R] = '{0, 1, 2, 0, 1, 2};
  int fr_p[R] = '{1, 2, 1, 2, 0, 0};
  int fr_f[R] = '{1, 1, 1, 1, 1, 1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic chk_state();
    chk("row_written",    32'(row_written),    32'(m_rw));
    chk("err_overflow",   32'(err_overflow),   32'(e_ovf));
    chk("err_oob",        32'(err_oob),        32'(e_oob));
    chk("err_incomplete", 32'(err_incomplete), 32'(e_inc));
  endtask

  // One clock: drive inputs, predict from pre-edge model state, score any beat, advance.
  task automatic cycle(input logic we, input int row, input int d, input logic cm, input logic rr);
    logic           ready;
    logic           valid;
    logic [W*R-1:0] frame;
    beat_t          b;
    wr_en            = we;
    write_row        = AW'(row);
    fm_wm_adj_row_in = W'(d);
    wr_commit        = cm;
    rd_ready         = rr;
    ready = (m_full != MAX_FULL);
    valid = (m_full != 0);
    chk("rd_valid", 32'(rd_valid), 32'(valid));
    chk("wr_ready", 32'(wr_ready), 32'(ready));
    if (valid) begin
      if (sbq.size() == 0) begin
        chk("sb_nonempty", 32'(sbq.size()), 32'd1);
      end else begin
        chk("rd_row",  32'(rd_row),        32'(sbq[0].row));
        chk("rd_data", 32'(rd_data),       32'(sbq[0].data));
        chk("rd_last", 32'(rd_last),       32'(sbq[0].last));
        chk("fm_out",  32'(fm_wm_adj_out), 32'(sbq[0].frame));
        if (rr) begin
          if (sbq[0].last) m_full--;
          void'(sbq.pop_front());
          beats++;
        end
      end
    end
    if (we) begin
      if (row >= R) e_oob = 1'b1;
      if (!ready) e_ovf = 1'b1;
      else if (row < R) begin
        m_mem[m_wb][row] = W'(d);
        m_rw[row] = 1'b1;
      end
    end
    if (cm) begin
      if (!ready) e_ovf = 1'b1;
      else begin
        if (m_rw != '1) e_inc = 1'b1;
        for (int r = 0; r < R; r++) frame[r*W +: W] = m_mem[m_wb][r];
        for (int r = 0; r < R; r++) begin
          b.row = AW'(r); b.data = m_mem[m_wb][r]; b.last = (r == R-1); b.frame = frame;
          sbq.push_back(b);
        end
        m_wb   = ~m_wb;
        m_full++;
        m_rw   = '0;
      end
    end
    @(posedge clk);
    #1;
    chk_state();
  endtask

  task automatic do_reset();
    wr_en = 1'b0; write_row = '0; fm_wm_adj_row_in = '0; wr_commit = 1'b0; rd_ready = 1'b1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int b = 0; b < 2; b++) for (int r = 0; r < R; r++) m_mem[b][r] = '0;
    m_wb = 1'b0; m_full = 0; m_rw = '0;
    e_ovf = 1'b0; e_oob = 1'b0; e_inc = 1'b0;
    sbq.delete();
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_rd_row",   32'(rd_row),   32'd0);
    chk_state();
  endtask

  task automatic write_frame(input int v[R], input int nrows, input logic rr);
    for (int r = 0; r < nrows; r++) cycle(1'b1, r, v[r], 1'b0, rr);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 1'b0, 1'b1);
  endtask

  initial begin
    int b0;
    rst = 1'b0;
    do_reset();

    // Basic frame with the consumer always ready.
    write_frame(fr_1, R, 1'b1);
    chk("full_rows", 32'(row_written), 32'h3f);
    cycle(1'b0, 0, 0, 1'b1, 1'b1);
    chk("valid_after_commit", 32'(rd_valid), 32'd1);
    b0 = beats;
    drain(7);
    chk("t1_beats", 32'(beats - b0), 32'd6);

    // Two frames queued, a third write is refused.
    write_frame(fr_a, R, 1'b0);
    cycle(1'b0, 0, 0, 1'b1, 1'b0);
    write_frame(fr_b, R, 1'b0);
    cycle(1'b0, 0, 0, 1'b1, 1'b0);
    chk("both_full", 32'(wr_ready), 32'd0);
    cycle(1'b1, 0, 1, 1'b0, 1'b0);
    chk("ovf_set", 32'(err_overflow), 32'd1);
    b0 = beats;
    drain(13);
    chk("t2_beats", 32'(beats - b0), 32'd12);

    // Commit on the same edge as the last beat of the read bank.
    write_frame(fr_c, R, 1'b0);
    cycle(1'b0, 0, 0, 1'b1, 1'b0);
    write_frame(fr_d, R, 1'b0);
    for (int i = 0; i < R-1; i++) cycle(1'b0, 0, 0, 1'b0, 1'b1);
    cycle(1'b0, 0, 0, 1'b1, 1'b1);
    chk("t3_valid", 32'(rd_valid), 32'd1);
    chk("t3_ready", 32'(wr_ready), 32'd1);
    b0 = beats;
    drain(7);
    chk("t3_beats", 32'(beats - b0), 32'd6);

    // Backpressure pattern 1,0,0,1.
    write_frame(fr_e, R, 1'b0);
    cycle(1'b0, 0, 0, 1'b1, 1'b0);
    b0 = beats;
    for (int i = 0; i < 40 && sbq.size() > 0; i++)
      cycle(1'b0, 0, 0, 1'b0, (i % 4 == 0) || (i % 4 == 3));
    chk("t4_beats", 32'(beats - b0), 32'd6);

    // Partial frame: rows 4..5 keep the stale contents of this bank.
    write_frame(fr_p, 4, 1'b0);
    cycle(1'b0, 0, 0, 1'b1, 1'b0);
    chk("inc_set", 32'(err_incomplete), 32'd1);
    drain(7);
    cycle(1'b1, 7, 3, 1'b0, 1'b0);
    chk("oob_set", 32'(err_oob), 32'd1);
    chk("oob_no_write", 32'(row_written), 32'd0);

    // Reset while a frame is mid-drain.
    write_frame(fr_f, R, 1'b0);
    cycle(1'b0, 0, 0, 1'b1, 1'b0);
    drain(3);
    do_reset();
    cycle(1'b0, 0, 0, 1'b1, 1'b0);
    b0 = beats;
    drain(7);
    chk("t6_beats", 32'(beats - b0), 32'd6);

    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
